ctrl_word_pipe: RTL
===================

CTRL_WORD_PIPE -- requirements
Module: ctrl_word_pipe

Interface
REQ-001 Parameter DEPTH, default 4, number of control-word stages (legal 1..8).
REQ-002 Parameter FLUSH_DEPTH, default 2, number of youngest stages (0..FLUSH_DEPTH-1) cleared by flush (legal 0..DEPTH).
REQ-003 Parameter NUM_SRC, default 2, number of source-register hazard query ports.
REQ-004 Ports SHALL be, in order: clk in 1 clock; rst_n in 1 asynchronous active-low reset; in_valid in 1 producer offers word; in_ready out 1 pipe accepts word; in_cw in ctrl_word_t control word; stall in 1 freeze all stages; flush in 1 kill young stages; out_valid out 1 oldest stage holds word; out_ready in 1 consumer takes word; out_cw out ctrl_word_t oldest word; chk_rs in NUM_SRC x 5 queried source registers; hazard out NUM_SRC RAW hazard per query; occupancy out clog2(DEPTH+1) count of valid stages.
REQ-005 One clock (clk); rst_n asynchronous, active-low; no other clock or reset.

Function
REQ-006 Stage i SHALL hold a valid bit and one ctrl_word_t; stage DEPTH-1 is oldest and drives out_valid/out_cw.
REQ-007 Transfer out SHALL occur when out_valid && out_ready && !stall.
REQ-008 Stage i<DEPTH-1 SHALL advance into i+1 when valid, !stall, and stage i+1 is empty or transferring/advancing that cycle (elastic, bubble-collapsing).
REQ-009 in_ready SHALL be !stall && !flush && (stage 0 empty || stage 0 advancing); acceptance = in_valid && in_ready.
REQ-010 Latency: word accepted at edge E SHALL reach out_valid after edge E+DEPTH-1 with no back-pressure; full throughput 1 word/cycle.
REQ-011 flush SHALL clear valid of stages 0..FLUSH_DEPTH-1 at the next edge, overrides stall and any advance into those stages; stages >= FLUSH_DEPTH behave normally (may advance/transfer).
REQ-012 stall SHALL freeze every stage (valid and data) and block input and output transfer; flush still applies.
REQ-013 occupancy SHALL equal the count of valid stages, registered, updated same edge as valid bits; never exceeds DEPTH.
REQ-014 hazard[k] SHALL be combinational: 1 iff some valid stage has load_regfile=1, rd==chk_rs[k], rd!=0.
REQ-015 chk_rs==0 SHALL never raise hazard.
REQ-016 When full (occupancy==DEPTH) and out_ready=0, in_ready SHALL be 0; when full and out transfer occurs, in_ready SHALL be 1 (simultaneous in/out allowed).
REQ-017 out_cw SHALL be don't-care-free: driven with stage contents even when out_valid=0.

Reset
REQ-018 rst_n low SHALL immediately clear all valid bits, occupancy=0, out_valid=0, hazard=0, stage data=0; in_ready=1 after release (absent stall/flush).
REQ-019 Reset mid-operation SHALL discard all in-flight words; none emerge after release.

Configuration
REQ-020 Macro CTRL_WORD_PIPE_FWD_EN: when defined, a matching stage whose word has read=0 (ALU result, forwardable) SHALL NOT raise hazard; only read=1 (load) matches raise hazard; output fwd_hit out NUM_SRC SHALL flag forwardable matches, taking youngest matching stage.
REQ-021 Without CTRL_WORD_PIPE_FWD_EN: any match raises hazard; fwd_hit port absent.

Structure
REQ-022 ctrl_word_t (opcode, aluop, cmpop, regfilemux_sel, rd, u_imm, load_regfile, read, write) and CWP_MAX_DEPTH=8 SHALL reside in rv32i_types.
REQ-023 One sub-module cwp_stage (valid+data register with load/clear) SHALL be instantiated DEPTH times via generate.

Verification
REQ-024 DEPTH=4, stream 6 words rd=1..6, out_ready=1 -> word1 out_valid after edge E+3, one per cycle, order preserved.
REQ-025 Fill 4 words, out_ready=0 -> occupancy=4, in_ready=0; raise out_ready with in_valid=1 -> simultaneous in/out, occupancy stays 4.
REQ-026 Words in all 4 stages, flush=1 with stall=1 -> stages 0,1 cleared, occupancy=2, stages 2,3 unchanged.
REQ-027 Stage 2 holds rd=5 load_regfile=1 read=0, chk_rs[0]=5 -> hazard[0]=1 without FWD_EN; hazard[0]=0, fwd_hit[0]=1 with FWD_EN; chk_rs[1]=0 -> hazard[1]=0.
REQ-028 rst_n low while 3 words in flight -> out_valid=0 immediately, occupancy=0; after release no stale word appears.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I control-word types used by the control-word pipeline.
// Holds ctrl_word_t and the depth ceiling CWP_MAX_DEPTH.
package rv32i_types;

  localparam int CWP_MAX_DEPTH = 8;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    rv32i_opcode    opcode;
    alu_ops         aluop;
    branch_funct3_t cmpop;
    logic [3:0]     regfilemux_sel;
    logic [4:0]     rd;
    logic [31:0]    u_imm;
    logic           load_regfile;
    logic           read;
    logic           write;
  } ctrl_word_t;

endpackage

// File: rtl/cwp_stage.sv
// One control-word pipeline stage: valid bit plus control word.
// clear has priority over load; data is only captured with a valid word,
// so an emptied stage keeps its last contents on the data bus.
module cwp_stage
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  logic       valid_d,
  input  ctrl_word_t data_d,
  output logic       valid,
  output ctrl_word_t data
);

  logic       valid_reg;
  ctrl_word_t data_reg;

  // Stage register: reset wipes everything, clear kills the word, load refills or empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= valid_d;
      if (valid_d) begin
        data_reg <= data_d;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/ctrl_word_pipe.sv
// Elastic, bubble-collapsing control-word pipeline with RAW hazard queries.
// Stage 0 is youngest, stage DEPTH-1 is oldest and feeds the output.
// Optional build macro: CTRL_WORD_PIPE_FWD_EN -- ALU-result matches are
// reported on fwd_hit instead of hazard; only load matches stall.
module ctrl_word_pipe
  import rv32i_types::*;
#(
  parameter int DEPTH       = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int NUM_SRC     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  ctrl_word_t                     in_cw,
  input  logic                           stall,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output ctrl_word_t                     out_cw,
  input  logic [NUM_SRC-1:0][4:0]        chk_rs,
  output logic [NUM_SRC-1:0]             hazard,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
`ifdef CTRL_WORD_PIPE_FWD_EN
  ,
  output logic [NUM_SRC-1:0]             fwd_hit
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] stage_valid;
  ctrl_word_t       stage_cw    [DEPTH];
  ctrl_word_t       incoming_cw [DEPTH];
  logic [DEPTH-1:0] clear;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] incoming;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] valid_next;
  logic             xfer_out;
  logic             accept;
  logic [OCC_W-1:0] occupancy_next;
  logic [OCC_W-1:0] occupancy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign clear[gi] = flush && (gi < FLUSH_DEPTH);

      if (gi == 0) begin : g_head
        assign incoming_cw[gi] = in_cw;
      end else begin : g_body
        assign incoming_cw[gi] = stage_cw[gi-1];
      end

      cwp_stage u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load[gi]),
        .clear   (clear[gi]),
        .valid_d (incoming[gi]),
        .data_d  (incoming_cw[gi]),
        .valid   (stage_valid[gi]),
        .data    (stage_cw[gi])
      );
    end
  endgenerate

  // Movement network, resolved oldest-first so a stage may advance into a slot being vacated.
  // A stage being flushed never hands its word onward, and a flushed oldest stage never transfers.
  always_comb begin
    xfer_out = stage_valid[DEPTH-1] && out_ready && !stall && !clear[DEPTH-1];
    move     = '0;
    move[DEPTH-1] = xfer_out;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      move[i] = stage_valid[i] && !stall && !clear[i] &&
                (!stage_valid[i+1] || move[i+1]);
    end

    in_ready = !stall && !flush && (!stage_valid[0] || move[0]);
    accept   = in_valid && in_ready;

    incoming    = '0;
    incoming[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      incoming[i] = move[i-1];
    end
    load = move | incoming;

    valid_next     = '0;
    occupancy_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (clear[i]) begin
        valid_next[i] = 1'b0;
      end else if (load[i]) begin
        valid_next[i] = incoming[i];
      end else begin
        valid_next[i] = stage_valid[i];
      end
      occupancy_next = occupancy_next + OCC_W'(valid_next[i]);
    end
  end

  // Occupancy tracks the valid bits on the same edge they change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  assign occupancy = occupancy_reg;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_cw    = stage_cw[DEPTH-1];

  // RAW hazard scan; stages are walked oldest to youngest so the youngest match is seen last.
  always_comb begin
    hazard = '0;
`ifdef CTRL_WORD_PIPE_FWD_EN
    fwd_hit = '0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (stage_valid[i] && stage_cw[i].load_regfile &&
            (stage_cw[i].rd == chk_rs[k]) && (stage_cw[i].rd != 5'd0)) begin
`ifdef CTRL_WORD_PIPE_FWD_EN
          if (stage_cw[i].read) begin
            hazard[k] = 1'b1;
          end
          fwd_hit[k] = !stage_cw[i].read;
`else
          hazard[k] = 1'b1;
`endif
        end
      end
    end
  end

endmodule
